// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Brief    : Packet sizing, field offsets and packing helper for the tree NoC.
// Revision : 1.0
// ============================================================================
package noc_pkg;

    localparam int C_LOG_N_ADD = 6;
    localparam int C_BIT_WIDTH = 16;
    localparam int C_VAL_BIT   = 1;

    function automatic int pkt_w(input int log_n_add, input int bit_width, input int val_bit);
        return val_bit + log_n_add + bit_width;
    endfunction

    localparam int C_PKT_W  = pkt_w(C_LOG_N_ADD, C_BIT_WIDTH, C_VAL_BIT);
    localparam int VAL_POS  = C_PKT_W - 1;
    localparam int DEST_LSB = C_BIT_WIDTH;

    typedef logic [C_PKT_W-1:0] pkt_t;

    // Layout is {valid, dest, data} with valid in the MSB.
    function automatic pkt_t pack_pkt(input logic                   valid,
                                      input logic [C_LOG_N_ADD-1:0] dest,
                                      input logic [C_BIT_WIDTH-1:0] data);
        pkt_t p;
        p                            = '0;
        p[VAL_POS]                   = valid;
        p[DEST_LSB +: C_LOG_N_ADD]   = dest;
        p[C_BIT_WIDTH-1:0]           = data;
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : noc_fifo
// Brief    : Occupancy-tracked circular buffer with combinational head read.
// Revision : 1.0
// ============================================================================
module noc_fifo #(
    parameter int WIDTH     = 22,
    parameter int LOG_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic                 i_pop,
    output logic [WIDTH-1:0]     o_head,
    output logic [LOG_DEPTH:0]   o_occupancy,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int                 DEPTH   = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] C_DEPTH = (LOG_DEPTH+1)'(DEPTH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [LOG_DEPTH-1:0] r_wr_ptr;
    logic [LOG_DEPTH-1:0] r_rd_ptr;
    logic [LOG_DEPTH:0]   r_occ;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full      = (r_occ == C_DEPTH);
    assign o_empty     = (r_occ == '0);
    assign w_do_push   = i_push && !o_full;
    assign w_do_pop    = i_pop && !o_empty;
    assign o_head      = r_mem[r_rd_ptr];
    assign o_occupancy = r_occ;

    // Storage is not reset; emptiness is carried entirely by r_occ.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_inject_port.sv
`default_nettype none
// ============================================================================
// Module   : noc_inject_port
// Brief    : Tags multiplier results with destination/valid and buffers them
//            toward a NoC leaf arbiter.
// Revision : 1.0
// ============================================================================
module noc_inject_port
    import noc_pkg::*;
#(
    parameter int LOG_N_ADD      = 6,
    parameter int BIT_WIDTH      = 16,
    parameter int VAL_BIT        = 1,
    parameter int LOG_BUFFER_LEN = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [BIT_WIDTH-1:0]                  in_data,
    input  logic [LOG_N_ADD-1:0]                  in_dest,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [VAL_BIT+LOG_N_ADD+BIT_WIDTH-1:0] out_pkt,
    input  logic                                  full_in,
    output logic [LOG_BUFFER_LEN:0]               occupancy,
    output logic                                  ovf
);

    localparam int ENTRY_W = LOG_N_ADD + BIT_WIDTH;

    logic [ENTRY_W-1:0] w_head;
    logic [ENTRY_W-1:0] w_head_masked;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               r_ovf;

    assign in_ready      = !w_full;
    assign w_push        = in_valid && in_ready;
    assign w_pop         = !w_empty && !full_in;
    assign w_head_masked = w_empty ? '0 : w_head;
    assign ovf           = r_ovf;

    noc_fifo #(
        .WIDTH     (ENTRY_W),
        .LOG_DEPTH (LOG_BUFFER_LEN)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_wdata     ({in_dest, in_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_occupancy (occupancy),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // The shared packer only covers the default tree geometry.
    if (LOG_N_ADD == C_LOG_N_ADD && BIT_WIDTH == C_BIT_WIDTH && VAL_BIT == C_VAL_BIT) begin : g_pkg_pack
        assign out_pkt = pack_pkt(!w_empty, w_head_masked[ENTRY_W-1 -: LOG_N_ADD],
                                  w_head_masked[BIT_WIDTH-1:0]);
    end else begin : g_generic_pack
        assign out_pkt = {{VAL_BIT{!w_empty}}, w_head_masked};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (in_valid && !in_ready) begin
            r_ovf <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_noc_inject_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_inject_port
// Brief    : Directed self-checking bench for noc_inject_port.
// Revision : 1.0
// ============================================================================
module tb_noc_inject_port;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data  = '0;
    logic [5:0]  in_dest  = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [22:0] out_pkt;
    logic        full_in  = 1'b0;
    logic [3:0]  occupancy;
    logic        ovf;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    noc_inject_port u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pkt   (out_pkt),
        .full_in   (full_in),
        .occupancy (occupancy),
        .ovf       (ovf)
    );

    function automatic logic [22:0] mk(input logic [5:0] dst, input logic [15:0] dat);
        return {1'b1, dst, dat};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [5:0] dst, input logic [15:0] dat);
        in_valid = 1'b1;
        in_dest  = dst;
        in_data  = dat;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();
    endtask

    logic [22:0] log_q[$];
    int          sent;
    int          got;

    initial begin
        // Power-on reset
        #2;
        chk("por_occ", 32'(occupancy), 32'd0);
        chk("por_pkt", 32'(out_pkt), 32'd0);
        chk("por_ovf", 32'(ovf), 32'd0);
        rst = 1'b1;
        #1;
        chk("por_ready", 32'(in_ready), 32'd1);
        step();

        // Asynchronous reset with three words buffered
        full_in = 1'b1;
        push_word(6'd1, 16'h0001);
        push_word(6'd2, 16'h0002);
        push_word(6'd3, 16'h0003);
        chk("t1_occ_pre", 32'(occupancy), 32'd3);
        #3;
        rst = 1'b0;
        #1;
        chk("t1_occ", 32'(occupancy), 32'd0);
        chk("t1_pkt", 32'(out_pkt), 32'd0);
        chk("t1_ovf", 32'(ovf), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_ready", 32'(in_ready), 32'd1);
        step();

        // Single word latency and pop
        full_in = 1'b0;
        push_word(6'd9, 16'h00A5);
        chk("t2_pkt", 32'(out_pkt), 32'h4900A5);
        chk("t2_occ1", 32'(occupancy), 32'd1);
        step();
        chk("t2_occ0", 32'(occupancy), 32'd0);
        chk("t2_pkt0", 32'(out_pkt), 32'd0);

        // Fill while throttled, then overflow attempt
        full_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push_word(6'(i), 16'(i));
        end
        chk("t3_occ", 32'(occupancy), 32'd8);
        chk("t3_ready", 32'(in_ready), 32'd0);
        chk("t3_head", 32'(out_pkt), 32'h410001);
        push_word(6'd9, 16'd9);
        chk("t3_ovf", 32'(ovf), 32'd1);
        chk("t3_occ_hold", 32'(occupancy), 32'd8);
        chk("t3_head_hold", 32'(out_pkt), 32'h410001);
        do_reset();
        chk("t3_ovf_clr", 32'(ovf), 32'd0);

        // Concurrent push and pop at occupancy 3
        full_in = 1'b1;
        push_word(6'd1, 16'h0011);
        push_word(6'd2, 16'h0022);
        push_word(6'd3, 16'h0033);
        chk("t4_head0", 32'(out_pkt), 32'h410011);
        full_in = 1'b0;
        push_word(6'd4, 16'h0044);
        chk("t4_occ", 32'(occupancy), 32'd3);
        chk("t4_head1", 32'(out_pkt), 32'h420022);
        step();
        chk("t4_head2", 32'(out_pkt), 32'h430033);
        step();
        chk("t4_head3", 32'(out_pkt), 32'h440044);
        step();
        chk("t4_empty", 32'(occupancy), 32'd0);

        // Stream of 20 words with toggling backpressure
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 300 && (sent < 20 || got < 20); cyc++) begin
            full_in  = (cyc % 2 == 1);
            in_valid = (sent < 20) && in_ready;
            in_dest  = sent[5:0];
            in_data  = 16'h0100 + sent[15:0];
            if (out_pkt[22] && !full_in) begin
                log_q.push_back(out_pkt);
                got++;
            end
            @(posedge clk);
            if (in_valid) sent++;
            #1;
        end
        in_valid = 1'b0;
        full_in  = 1'b0;
        chk("t5_count", 32'(got), 32'd20);
        foreach (log_q[k]) begin
            chk($sformatf("t5_word%0d", k), 32'(log_q[k]), 32'(mk(6'(k), 16'h0100 + 16'(k))));
        end
        chk("t5_ovf", 32'(ovf), 32'd0);
        chk("t5_occ", 32'(occupancy), 32'd0);

        // Push offered at full while a pop drains
        full_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_word(6'(i), 16'h0200 + 16'(i));
        end
        full_in  = 1'b0;
        in_valid = 1'b1;
        in_dest  = 6'd10;
        in_data  = 16'h0099;
        #0;
        chk("t6_ready_lo", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0;
        chk("t6_ovf", 32'(ovf), 32'd1);
        chk("t6_occ", 32'(occupancy), 32'd7);
        chk("t6_ready_hi", 32'(in_ready), 32'd1);
        chk("t6_head", 32'(out_pkt), 32'h410201);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
